// File: rtl/mode_count_checker.sv
// rtl/mode_count_checker.sv - receive-side checker for an up/down mode counter stream
module mode_count_checker #(
    parameter int sz     = 8,
    parameter int LOCK_N = 4,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             valid,
    input  logic             mode,
    input  logic [sz-1:0]    count,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

    localparam logic [sz-1:0]    ONE_S    = {{(sz-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ONE_E    = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       LOCK_RUN = 8'(LOCK_N);

    state_t             state, state_n;
    logic [sz-1:0]      prev, exp_val;
    logic [7:0]         run, run_n;
    logic               locked_n, err_n, wrap_n;
    logic [ERR_W-1:0]   err_count_n;
    logic               match, wraps;

    assign exp_val = mode ? (prev - ONE_S) : (prev + ONE_S);
    assign match   = (count == exp_val);
    // Given a match, the step wrapped iff prev sat on the boundary for this direction.
    assign wraps   = mode ? (prev == '0) : (prev == '1);

    always_comb begin
        state_n     = state;
        run_n       = run;
        locked_n    = locked;
        err_n       = 1'b0;
        wrap_n      = 1'b0;
        err_count_n = err_count;
        if (valid) begin
            case (state)
                IDLE: begin
                    state_n = SYNC;
                    run_n   = 8'd0;
                end
                SYNC: begin
                    if (match) begin
                        wrap_n = wraps;
                        run_n  = run + 8'd1;
                        if (run_n == LOCK_RUN) begin
                            state_n  = LOCKED;
                            locked_n = 1'b1;
                        end
                    end else begin
                        run_n = 8'd0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        wrap_n = wraps;
                    end else begin
                        err_n    = 1'b1;
                        state_n  = SYNC;
                        run_n    = 8'd0;
                        locked_n = 1'b0;
                        if (err_count != '1)
                            err_count_n = err_count + ONE_E;
                    end
                end
                default: begin
                    state_n  = IDLE;
                    run_n    = 8'd0;
                    locked_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            prev      <= '0;
            run       <= 8'd0;
            locked    <= 1'b0;
            err       <= 1'b0;
            wrap      <= 1'b0;
            err_count <= '0;
        end else if (clr) begin
            state     <= IDLE;
            prev      <= '0;
            run       <= 8'd0;
            locked    <= 1'b0;
            err       <= 1'b0;
            wrap      <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            run       <= run_n;
            locked    <= locked_n;
            err       <= err_n;
            wrap      <= wrap_n;
            err_count <= err_count_n;
            if (valid)
                prev <= count;
        end
    end

endmodule

// File: tb/tb_mode_count_checker.sv
// tb/tb_mode_count_checker.sv - scoreboard bench for mode_count_checker
module tb_mode_count_checker;

    logic       clk = 1'b0;
    logic       reset, clr, valid, mode;
    logic [7:0] count;
    logic       locked, err, wrap;
    logic [1:0] err_count;

    typedef struct packed {
        logic       l;
        logic       e;
        logic       w;
        logic [1:0] c;
        logic [15:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_err_pulses = 0;
    int   vec_id = 0;

    mode_count_checker #(.sz(8), .LOCK_N(4), .ERR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .valid     (valid),
        .mode      (mode),
        .count     (count),
        .locked    (locked),
        .err       (err),
        .wrap      (wrap),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int id, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0d, expected %0d", name, id, act, req);
        end
    endfunction

    task automatic s(input logic c_clr, input logic v, input logic m, input logic [7:0] c,
                     input logic el, input logic ee, input logic ew, input logic [1:0] ec);
        exp_t x;
        @(negedge clk);
        clr   = c_clr;
        valid = v;
        mode  = m;
        count = c;
        x.l = el; x.e = ee; x.w = ew; x.c = ec; x.id = 16'(vec_id);
        vec_id++;
        exp_q.push_back(x);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".locked"},    -1, int'(locked),    0);
        check({tag, ".err"},       -1, int'(err),       0);
        check({tag, ".wrap"},      -1, int'(wrap),      0);
        check({tag, ".err_count"}, -1, int'(err_count), 0);
    endtask

    // Monitor: the DUT presents registered outputs after every edge that follows a stimulus.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            check("locked",    int'(x.id), int'(locked),    int'(x.l));
            check("err",       int'(x.id), int'(err),       int'(x.e));
            check("wrap",      int'(x.id), int'(wrap),      int'(x.w));
            check("err_count", int'(x.id), int'(err_count), int'(x.c));
            if (err) n_err_pulses++;
        end
    end

    initial begin
        reset = 1'b0; clr = 1'b0; valid = 1'b0; mode = 1'b0; count = 8'd0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk) reset = 1'b1;

        // lock on 0..4
        s(0,1,0,8'd0,   0,0,0,2'd0);
        s(0,1,0,8'd1,   0,0,0,2'd0);
        s(0,1,0,8'd2,   0,0,0,2'd0);
        s(0,1,0,8'd3,   0,0,0,2'd0);
        s(0,1,0,8'd4,   1,0,0,2'd0);

        // wrap up and down
        s(1,1,0,8'd99,  0,0,0,2'd0);
        s(0,1,0,8'd250, 0,0,0,2'd0);
        s(0,1,0,8'd251, 0,0,0,2'd0);
        s(0,1,0,8'd252, 0,0,0,2'd0);
        s(0,1,0,8'd253, 0,0,0,2'd0);
        s(0,1,0,8'd254, 1,0,0,2'd0);
        s(0,1,0,8'd255, 1,0,0,2'd0);
        s(0,1,0,8'd0,   1,0,1,2'd0);
        s(0,1,0,8'd1,   1,0,0,2'd0);
        s(0,1,1,8'd0,   1,0,0,2'd0);
        s(0,1,1,8'd255, 1,0,1,2'd0);
        s(0,1,1,8'd254, 1,0,0,2'd0);

        // mode reversal, injected error, relock
        s(1,1,0,8'd0,   0,0,0,2'd0);
        s(0,1,0,8'd6,   0,0,0,2'd0);
        s(0,1,0,8'd7,   0,0,0,2'd0);
        s(0,1,0,8'd8,   0,0,0,2'd0);
        s(0,1,0,8'd9,   0,0,0,2'd0);
        s(0,1,0,8'd10,  1,0,0,2'd0);
        s(0,1,0,8'd11,  1,0,0,2'd0);
        s(0,1,1,8'd10,  1,0,0,2'd0);
        s(0,1,1,8'd9,   1,0,0,2'd0);
        s(0,1,1,8'd20,  0,1,0,2'd1);
        s(0,1,1,8'd19,  0,0,0,2'd1);
        s(0,1,1,8'd18,  0,0,0,2'd1);
        s(0,1,1,8'd17,  0,0,0,2'd1);
        s(0,1,1,8'd16,  1,0,0,2'd1);

        // valid gaps and held value while syncing
        s(0,1,0,8'd5,   0,1,0,2'd2);
        s(0,0,0,8'd77,  0,0,0,2'd2);
        s(0,0,0,8'd77,  0,0,0,2'd2);
        s(0,0,0,8'd77,  0,0,0,2'd2);
        s(0,1,0,8'd6,   0,0,0,2'd2);
        s(0,1,0,8'd7,   0,0,0,2'd2);
        s(0,1,0,8'd7,   0,0,0,2'd2);
        s(0,1,0,8'd8,   0,0,0,2'd2);
        s(0,1,0,8'd9,   0,0,0,2'd2);
        s(0,1,0,8'd10,  0,0,0,2'd2);
        s(0,0,0,8'd0,   0,0,0,2'd2);
        s(0,1,0,8'd11,  1,0,0,2'd2);

        // saturating error counter
        s(0,1,0,8'd50,  0,1,0,2'd3);
        s(0,1,0,8'd51,  0,0,0,2'd3);
        s(0,1,0,8'd52,  0,0,0,2'd3);
        s(0,1,0,8'd53,  0,0,0,2'd3);
        s(0,1,0,8'd54,  1,0,0,2'd3);
        s(0,1,0,8'd100, 0,1,0,2'd3);
        s(0,1,0,8'd101, 0,0,0,2'd3);
        s(0,1,0,8'd102, 0,0,0,2'd3);
        s(0,1,0,8'd103, 0,0,0,2'd3);
        s(0,1,0,8'd104, 1,0,0,2'd3);
        s(0,1,0,8'd200, 0,1,0,2'd3);
        s(0,1,0,8'd201, 0,0,0,2'd3);
        s(0,1,0,8'd202, 0,0,0,2'd3);
        s(0,1,0,8'd203, 0,0,0,2'd3);
        s(0,1,0,8'd204, 1,0,0,2'd3);

        // clr with valid discards the sample; next one only seeds
        s(1,1,0,8'd205, 0,0,0,2'd0);
        s(0,1,0,8'd205, 0,0,0,2'd0);
        s(0,1,0,8'd206, 0,0,0,2'd0);
        s(0,1,0,8'd207, 0,0,0,2'd0);
        s(0,1,0,8'd208, 0,0,0,2'd0);
        s(0,1,0,8'd209, 1,0,0,2'd0);

        // async reset while locked
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clk) valid = 1'b0;
        @(negedge clk) reset = 1'b1;
        s(0,1,0,8'd3,   0,0,0,2'd0);
        s(0,1,0,8'd4,   0,0,0,2'd0);
        s(0,1,0,8'd5,   0,0,0,2'd0);
        s(0,1,0,8'd6,   0,0,0,2'd0);
        s(0,1,0,8'd7,   1,0,0,2'd0);
        s(0,0,0,8'd0,   1,0,0,2'd0);

        begin
            int budget;
            budget = 0;
            while (exp_q.size() > 0 && budget < 20) begin
                @(posedge clk);
                budget++;
            end
            #2;
            check("scoreboard_drain", -1, exp_q.size(), 0);
        end
        check("err_pulses", -1, n_err_pulses, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
